log_uart_tx: RTL and testbench
==============================

# log_uart_tx

Downstream consumer of the logging FIR's RAM unload port. During unload (enable bit 2), the logger presents one `NB_DATA`-bit word per cycle. This block buffers those words in a small synchronous FIFO and serializes them as asynchronous UART frames (start, data LSB-first, stop) on a single pin for capture by a host. Backpressure is exposed with `o_ready`; words offered while not ready are dropped and flagged.

## Interface
Parameters:
- `NB_DATA`, 8, data word width; also the number of data bits per frame
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 2
- `NB_BAUD`, 10, baud counter width; must satisfy 2^`NB_BAUD` ≥ `CLKS_PER_BIT`
- `FIFO_DEPTH_LOG2`, 4, FIFO holds 2^`FIFO_DEPTH_LOG2` words

Ports:
- `clock`  in  1  system clock; all logic on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_data`  in  `NB_DATA`  word from log RAM unload
- `i_valid`  in  1  `i_data` valid this cycle
- `o_ready`  out  1  FIFO can accept; transfer occurs when `i_valid` && `o_ready`
- `o_tx`  out  1  UART line, idle high, registered
- `o_busy`  out  1  high while a frame is on the line or the FIFO is non-empty
- `o_overflow`  out  1  sticky: set when `i_valid` && !`o_ready`; cleared only by reset

## Operation
- FIFO: read/write pointers `FIFO_DEPTH_LOG2` bits wide, wrapping naturally; occupancy counter `FIFO_DEPTH_LOG2`+1 bits wide.
- `o_ready` = !full, derived from the registered count.
- Push when `i_valid` && `o_ready`.
- No bypass: a word written into an empty FIFO becomes visible to the TX FSM the following cycle.
- Simultaneous push and pop: allowed whenever not full; count unchanged. When full, a push is refused even if a pop happens in the same cycle.
- TX FSM states: IDLE → START → DATA → [PARITY] → STOP.
  - IDLE: `o_tx`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `o_tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA: `NB_DATA` bits, LSB first, each bit `CLKS_PER_BIT` cycles; bit index counter counts 0..`NB_DATA`-1.
  - STOP: `o_tx`=1 for `CLKS_PER_BIT` cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1 and resets to 0 on every state change.
- `o_busy` = (state != IDLE) || (count != 0).
- Reset values: `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_overflow`=0, FIFO empty, state IDLE, counters 0.
- Reset asserted mid-frame aborts the frame; `o_tx` is 1 after the reset edge and buffered words are discarded.

## Timing
- Push accepted at edge k → FSM pops at edge k+1 → `o_tx` falls after edge k+2 (registered output).
- Frame length: (`NB_DATA`+2)·`CLKS_PER_BIT` cycles, or (`NB_DATA`+3)·`CLKS_PER_BIT` cycles with parity.
- Back-to-back frames are contiguous: a stop bit is followed immediately by the next start bit.
- `o_overflow` rises one edge after the offending cycle.

## Configuration
- `LOG_UART_PARITY_EN` defined: PARITY state is inserted between DATA and STOP and drives even parity (XOR of data bits) for `CLKS_PER_BIT` cycles.
- `LOG_UART_PARITY_EN` undefined: PARITY state and its logic are absent; DATA goes directly to STOP.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 unless noted.
- Single word 0xA5 pushed after reset → `o_tx` low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high; `o_busy` drops after the stop bit.
- Words 0x00 then 0xFF on consecutive cycles → 80 contiguous cycles on the line, no idle cycle between the first stop bit and the second start bit.
- `i_valid` held high with 20 distinct words → exactly 17 accepted before `o_ready` falls; `o_overflow`=1 one edge later; the 17 words appear on the line in order.
- Reset during the DATA state of a frame → `o_tx`=1, `o_busy`=0, `o_ready`=1, `o_overflow`=0 after the reset edge; no further bits transmitted.
- `LOG_UART_PARITY_EN` defined, word 0x07 → parity bit 1, frame length 44 cycles; word 0x03 → parity bit 0.
- `CLKS_PER_BIT`=868, word 0x55 → each bit exactly 868 cycles, measured edge to edge.

Source files
------------

// File: rtl/log_uart_tx.sv
// log_uart_tx: buffers log RAM unload words in a small synchronous FIFO and
// serializes them as UART frames (start, data LSB first, stop) on o_tx.
// Optional even parity bit between data and stop: define LOG_UART_PARITY_EN.
`timescale 1ns/1ps
module log_uart_tx #(
  parameter int NB_DATA         = 8,
  parameter int CLKS_PER_BIT    = 868,
  parameter int NB_BAUD         = 10,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_overflow
);

  localparam int NB_IDX = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;

  localparam logic [NB_BAUD-1:0]         BAUD_LAST  = NB_BAUD'(CLKS_PER_BIT - 1);
  localparam logic [NB_BAUD-1:0]         BAUD_ONE   = NB_BAUD'(1);
  localparam logic [NB_IDX-1:0]          IDX_LAST   = NB_IDX'(NB_DATA - 1);
  localparam logic [NB_IDX-1:0]          IDX_ONE    = NB_IDX'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE    = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

`ifdef LOG_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [NB_DATA-1:0]         mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       push;
  logic                       pop;
  logic                       fifo_empty;

  // Transmitter
  state_t             state;
  state_t             state_next;
  logic [NB_BAUD-1:0] baud;
  logic [NB_IDX-1:0]  bit_idx;
  logic [NB_DATA-1:0] tx_word;
  logic               tx_bit;
  logic               baud_done;

  // Ready comes only from the registered count, so a pop in the same cycle
  // never lets a push into a full FIFO.
  assign o_ready    = (count != COUNT_FULL);
  assign push       = i_valid && o_ready;
  assign fifo_empty = (count == '0);
  assign baud_done  = (baud == BAUD_LAST);
  assign o_busy     = (state != S_IDLE) || !fifo_empty;

  // FIFO pointers and occupancy; pointers wrap naturally at the FIFO depth
  always_ff @(posedge clock) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // FIFO word storage (data only, no reset)
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // Word being transmitted; loaded from the FIFO head on every pop
  always_ff @(posedge clock) begin
    if (pop) tx_word <= mem[rd_ptr];
  end

  // Sticky overflow flag for words offered while the FIFO was full
  always_ff @(posedge clock) begin
    if (i_reset)                  o_overflow <= 1'b0;
    else if (i_valid && !o_ready) o_overflow <= 1'b1;
  end

  // Next-state, pop request and line level for the current state
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_bit     = 1'b1;
    case (state)
      S_IDLE: begin
        tx_bit = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (baud_done) state_next = S_DATA;
      end
      S_DATA: begin
        tx_bit = tx_word[bit_idx];
        if (baud_done && (bit_idx == IDX_LAST)) begin
`ifdef LOG_UART_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef LOG_UART_PARITY_EN
      S_PARITY: begin
        tx_bit = ^tx_word;
        if (baud_done) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        tx_bit = 1'b1;
        // Chain straight into the next start bit so frames stay contiguous
        if (baud_done) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, baud/bit counters and the registered line output
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      o_tx    <= 1'b1;
    end else begin
      state <= state_next;
      o_tx  <= tx_bit;
      if ((state_next != state) || (state == S_IDLE) || baud_done) baud <= '0;
      else                                                         baud <= baud + BAUD_ONE;
      if (state != S_DATA) bit_idx <= '0;
      else if (baud_done)  bit_idx <= bit_idx + IDX_ONE;
    end
  end

endmodule

// File: tb/tb_log_uart_tx.sv
// tb_log_uart_tx: randomized scenarios for log_uart_tx checked against a
// frame-timing reference model (frame start = max(push+2, previous end)).
`timescale 1ns/1ps
module tb_log_uart_tx;

  localparam int NB_DATA  = 8;
  localparam int CPB      = 4;
  localparam int CPB_SLOW = 868;
  localparam int DEPTH    = 16;
`ifdef LOG_UART_PARITY_EN
  localparam int NBITS  = NB_DATA + 3;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NBITS  = NB_DATA + 2;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int L     = NBITS * CPB;
  localparam int NEVER = 32'h7fffffff;

  logic       clock = 1'b0;
  logic       i_reset = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready, o_tx, o_busy, o_overflow;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready, s_tx, s_busy, s_overflow;

  always #5 clock = ~clock;

  log_uart_tx #(.NB_DATA(NB_DATA), .CLKS_PER_BIT(CPB), .NB_BAUD(10), .FIFO_DEPTH_LOG2(4)) dut (
    .clock(clock), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_overflow(o_overflow));

  log_uart_tx #(.NB_DATA(NB_DATA), .CLKS_PER_BIT(CPB_SLOW), .NB_BAUD(10), .FIFO_DEPTH_LOG2(4)) dut_slow (
    .clock(clock), .i_reset(i_reset), .i_data(s_data), .i_valid(s_valid),
    .o_ready(s_ready), .o_tx(s_tx), .o_busy(s_busy), .o_overflow(s_overflow));

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: accepted words with their push edge and first start-bit sample
  int         p_q[$];
  int         s_q[$];
  logic [7:0] w_q[$];
  int         ovf_edge = NEVER;
  bit         mon_en = 1'b0;
  int         err_tx, err_busy, err_rdy, err_ovf, bad_cyc;

  function automatic logic frame_bit(input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= NB_DATA) return w[b-1];
    if (PAR_EN && b == NB_DATA + 1) return ^w;
    return 1'b1;
  endfunction

  function automatic logic exp_tx(input int e);
    foreach (s_q[i]) if (e >= s_q[i] && e < s_q[i] + L) return frame_bit(w_q[i], (e - s_q[i]) / CPB);
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int e);
    foreach (s_q[i]) if (e >= p_q[i] && e <= s_q[i] + L - 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_count(input int e);
    int n = 0;
    foreach (s_q[i]) begin
      if (p_q[i] <= e)     n++;
      if (s_q[i] - 1 <= e) n--;
    end
    return n;
  endfunction

  task automatic clear_errs();
    err_tx = 0; err_busy = 0; err_rdy = 0; err_ovf = 0; bad_cyc = -1;
  endtask

  // Advance to the next falling edge and score the fast DUT against the model
  task automatic tick();
    @(negedge clock);
    if (mon_en) begin
      if (o_tx !== exp_tx(cyc)) begin
        if (err_tx == 0) bad_cyc = cyc;
        err_tx++;
      end
      if (o_busy !== exp_busy(cyc))                 err_busy++;
      if (o_ready !== (exp_count(cyc) < DEPTH))     err_rdy++;
      if (o_overflow !== (cyc >= ovf_edge))         err_ovf++;
    end
  endtask

  task automatic offer(input logic [7:0] w);
    int p, s;
    i_valid = 1'b1;
    i_data  = w;
    if (exp_count(cyc) < DEPTH) begin
      p = cyc + 1;
      s = p + 2;
      if (s_q.size() > 0 && s_q[s_q.size()-1] + L > s) s = s_q[s_q.size()-1] + L;
      p_q.push_back(p); s_q.push_back(s); w_q.push_back(w);
    end else if (ovf_edge > cyc + 1) begin
      ovf_edge = cyc + 1;
    end
  endtask

  task automatic send_one(input logic [7:0] w);
    tick();
    offer(w);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int stop_at;
    stop_at = cyc + 2;
    if (s_q.size() > 0 && s_q[s_q.size()-1] + L + 2 > stop_at) stop_at = s_q[s_q.size()-1] + L + 2;
    while (cyc < stop_at) tick();
  endtask

  task automatic do_reset();
    tick();
    mon_en  = 1'b0;
    i_reset = 1'b1;
    i_valid = 1'b0;
    s_valid = 1'b0;
    tick();
    i_reset = 1'b0;
    p_q.delete(); s_q.delete(); w_q.delete();
    ovf_edge = NEVER;
    mon_en   = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (o_tx !== 1'b1)       $display("FAIL reset_tx: got %b, expected 1", o_tx); else n_pass++;
    n_checks++; if (o_ready !== 1'b1)    $display("FAIL reset_ready: got %b, expected 1", o_ready); else n_pass++;
    n_checks++; if (o_busy !== 1'b0)     $display("FAIL reset_busy: got %b, expected 0", o_busy); else n_pass++;
    n_checks++; if (o_overflow !== 1'b0) $display("FAIL reset_overflow: got %b, expected 0", o_overflow); else n_pass++;
  endtask

  task automatic test_single();
    logic [8:0] got;
    got = '0;
    clear_errs();
    send_one(8'hA5);
    n_checks++; if (o_busy !== 1'b1) $display("FAIL single_busy_after_push: got %b, expected 1", o_busy); else n_pass++;
    tick();
    n_checks++; if (o_tx !== 1'b1) $display("FAIL single_tx_before_start: got %b, expected 1", o_tx); else n_pass++;
    tick();
    n_checks++; if (o_tx !== 1'b0) $display("FAIL single_start_edge: got %b, expected 0", o_tx); else n_pass++;
    for (int i = 0; i < 9 * CPB; i++) begin
      if (i % CPB == 1) got[i / CPB] = o_tx;
      tick();
    end
    n_checks++; if (got !== {8'hA5, 1'b0}) $display("FAIL single_a5_bits: got %b, expected %b", got, {8'hA5, 1'b0}); else n_pass++;
    drain();
    n_checks++; if (o_busy !== 1'b0) $display("FAIL single_busy_after_stop: got %b, expected 0", o_busy); else n_pass++;
    n_checks++;
    if ((err_tx + err_busy + err_rdy + err_ovf) !== 0)
      $display("FAIL single_wave: bad cycles tx=%0d busy=%0d ready=%0d ovf=%0d first_tx@%0d, expected all 0", err_tx, err_busy, err_rdy, err_ovf, bad_cyc);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic line [200];
    int   runs [3];
    int   r;
    logic prev;
    clear_errs();
    tick();
    offer(8'h00);
    tick();
    offer(8'hFF);
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 2 * L + 8; i++) begin
      line[i] = o_tx;
      tick();
    end
    runs[0] = 0; runs[1] = 0; runs[2] = 0;
    r = -1; prev = 1'b1;
    for (int i = 0; i < 2 * L + 8; i++) begin
      if (line[i] !== prev) begin r++; prev = line[i]; end
      if (r >= 0 && r < 3) runs[r]++;
    end
    n_checks++; if (runs[0] !== (NBITS - 1) * CPB) $display("FAIL b2b_first_low: got %0d, expected %0d", runs[0], (NBITS - 1) * CPB); else n_pass++;
    n_checks++; if (runs[1] !== CPB) $display("FAIL b2b_stop_gap: got %0d, expected %0d", runs[1], CPB); else n_pass++;
    n_checks++; if (runs[2] !== CPB) $display("FAIL b2b_second_start: got %0d, expected %0d", runs[2], CPB); else n_pass++;
    drain();
    n_checks++;
    if ((err_tx + err_busy + err_rdy + err_ovf) !== 0)
      $display("FAIL b2b_wave: bad cycles tx=%0d busy=%0d ready=%0d ovf=%0d first_tx@%0d, expected all 0", err_tx, err_busy, err_rdy, err_ovf, bad_cyc);
    else n_pass++;
  endtask

  task automatic test_parity();
    logic [7:0] words [2];
    int   busy_cnt, s;
    logic pbit;
    words[0] = 8'h07;
    words[1] = 8'h03;
    clear_errs();
    for (int k = 0; k < 2; k++) begin
      send_one(words[k]);
      s = s_q[s_q.size()-1];
      busy_cnt = 0;
      pbit = 1'bx;
      for (int i = 0; i < L + 6; i++) begin
        if (o_busy === 1'b1) busy_cnt++;
        if (cyc == s + (NB_DATA + 1) * CPB + 1) pbit = o_tx;
        tick();
      end
      n_checks++; if (busy_cnt !== L + 1) $display("FAIL parity_frame_len_%0d: got %0d busy cycles, expected %0d", k, busy_cnt, L + 1); else n_pass++;
      n_checks++;
      if (pbit !== (PAR_EN ? ^words[k] : 1'b1)) $display("FAIL parity_bit_%0d: got %b, expected %b", k, pbit, PAR_EN ? ^words[k] : 1'b1);
      else n_pass++;
      drain();
    end
    n_checks++;
    if ((err_tx + err_busy + err_rdy + err_ovf) !== 0)
      $display("FAIL parity_wave: bad cycles tx=%0d busy=%0d ready=%0d ovf=%0d first_tx@%0d, expected all 0", err_tx, err_busy, err_rdy, err_ovf, bad_cyc);
    else n_pass++;
  endtask

  task automatic test_random();
    int gap;
    clear_errs();
    for (int k = 0; k < 10; k++) begin
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 2 * L));
      repeat (gap) tick();
      send_one(8'($urandom));
    end
    drain();
    n_checks++;
    if ((err_tx + err_busy + err_rdy + err_ovf) !== 0)
      $display("FAIL random_wave: bad cycles tx=%0d busy=%0d ready=%0d ovf=%0d first_tx@%0d, expected all 0", err_tx, err_busy, err_rdy, err_ovf, bad_cyc);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] base;
    int   accepted;
    bit   refused;
    logic rdy, ovf;
    base = 8'($urandom);
    accepted = 0;
    refused  = 1'b0;
    clear_errs();
    tick();
    for (int k = 0; k < 20; k++) begin
      rdy = o_ready;
      ovf = o_overflow;
      if (!rdy) refused = 1'b1;
      if (rdy && !refused) accepted++;
      if (k == 17) begin
        n_checks++; if (rdy !== 1'b0) $display("FAIL ovf_ready_falls: got %b, expected 0", rdy); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_before_refusal: got %b, expected 0", ovf); else n_pass++;
      end
      if (k == 18) begin
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_one_edge_after: got %b, expected 1", ovf); else n_pass++;
      end
      offer(base + 8'(k));
      tick();
    end
    i_valid = 1'b0;
    n_checks++; if (accepted !== 17) $display("FAIL ovf_accepted: got %0d, expected 17", accepted); else n_pass++;
    drain();
    n_checks++; if (o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, expected 1", o_overflow); else n_pass++;
    n_checks++;
    if ((err_tx + err_busy + err_rdy + err_ovf) !== 0)
      $display("FAIL ovf_wave: bad cycles tx=%0d busy=%0d ready=%0d ovf=%0d first_tx@%0d, expected all 0", err_tx, err_busy, err_rdy, err_ovf, bad_cyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int s1;
    clear_errs();
    tick();
    offer(8'($urandom));
    s1 = s_q[s_q.size()-1];
    tick();
    offer(8'($urandom));
    tick();
    i_valid = 1'b0;
    while (cyc < s1 + 3 * CPB + 1) tick();
    do_reset();
    n_checks++; if (o_tx !== 1'b1)       $display("FAIL midreset_tx: got %b, expected 1", o_tx); else n_pass++;
    n_checks++; if (o_busy !== 1'b0)     $display("FAIL midreset_busy: got %b, expected 0", o_busy); else n_pass++;
    n_checks++; if (o_ready !== 1'b1)    $display("FAIL midreset_ready: got %b, expected 1", o_ready); else n_pass++;
    n_checks++; if (o_overflow !== 1'b0) $display("FAIL midreset_overflow: got %b, expected 0", o_overflow); else n_pass++;
    repeat (3 * L) tick();
    n_checks++;
    if ((err_tx + err_busy + err_rdy + err_ovf) !== 0)
      $display("FAIL midreset_wave: bad cycles tx=%0d busy=%0d ready=%0d ovf=%0d first_tx@%0d, expected all 0", err_tx, err_busy, err_rdy, err_ovf, bad_cyc);
    else n_pass++;
  endtask

  task automatic test_slow_baud();
    int   trans[$];
    int   off[$];
    int   p, nmin;
    logic lvl, prev;
    lvl = 1'b1;
    for (int b = 0; b < NBITS; b++) begin
      if (frame_bit(8'h55, b) !== lvl) begin
        off.push_back(b);
        lvl = frame_bit(8'h55, b);
      end
    end
    tick();
    s_valid = 1'b1;
    s_data  = 8'h55;
    p = cyc + 1;
    tick();
    s_valid = 1'b0;
    prev = 1'b1;
    for (int i = 0; i < NBITS * CPB_SLOW + 20; i++) begin
      if (s_tx !== prev) begin
        trans.push_back(cyc);
        prev = s_tx;
      end
      tick();
    end
    n_checks++; if (trans.size() !== off.size()) $display("FAIL slow_edge_count: got %0d, expected %0d", trans.size(), off.size()); else n_pass++;
    if (trans.size() > 0) begin
      n_checks++; if (trans[0] !== p + 2) $display("FAIL slow_latency: got edge %0d, expected %0d", trans[0], p + 2); else n_pass++;
    end
    nmin = (trans.size() < off.size()) ? trans.size() : off.size();
    for (int j = 1; j < nmin; j++) begin
      n_checks++;
      if (trans[j] - trans[j-1] !== (off[j] - off[j-1]) * CPB_SLOW)
        $display("FAIL slow_bit_%0d: got %0d cycles, expected %0d", j, trans[j] - trans[j-1], (off[j] - off[j-1]) * CPB_SLOW);
      else n_pass++;
    end
    n_checks++; if (s_busy !== 1'b0) $display("FAIL slow_busy_end: got %b, expected 0", s_busy); else n_pass++;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_errs();
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_random();
    test_overflow();
    test_reset_mid_frame();
    test_slow_baud();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
